// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART command parser: ASCII codes, state encoding, widths.
package uart_cmd_parser_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned NIB_W  = 5;

   localparam logic [BYTE_W-1:0] ASCII_S  = 8'h53;
   localparam logic [BYTE_W-1:0] ASCII_P  = 8'h50;
   localparam logic [BYTE_W-1:0] ASCII_E  = 8'h45;
   localparam logic [BYTE_W-1:0] ASCII_D  = 8'h44;
   localparam logic [BYTE_W-1:0] ASCII_C  = 8'h43;
   localparam logic [BYTE_W-1:0] ASCII_K  = 8'h4B;
   localparam logic [BYTE_W-1:0] ASCII_O  = 8'h4F;
   localparam logic [BYTE_W-1:0] ASCII_X  = 8'h58;
   localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
   localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
   localparam logic [BYTE_W-1:0] ASCII_SP = 8'h20;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_KEY  = 1'b1
   } state_e;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> nibble plus validity flag.
module ascii_hex_decode
   import uart_cmd_parser_pkg::*;
(
   input  logic [BYTE_W-1:0] data_i,
   output logic              is_hex_o,
   output logic [3:0]        nibble_o
);

   always_comb begin
      is_hex_o = 1'b0;
      nibble_o = 4'h0;
      if (data_i >= 8'h30 && data_i <= 8'h39) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(data_i - 8'h30);
      end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(data_i - 8'h37);
      end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(data_i - 8'h57);
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Host UART command parser: single-letter commands drive work/enc/clr_cnt, 'K' loads a
// 32-digit hex key; every command is answered with one ack byte on a one-entry register.
module uart_cmd_parser
   import uart_cmd_parser_pkg::*;
#(
   parameter int unsigned      CLK_FREQ    = 50_000_000,
   parameter int unsigned      TIMEOUT_MS  = 100,
   parameter logic             ENC_DEFAULT = 1'b1,
   parameter logic [KEY_W-1:0] KEY_DEFAULT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              work,
   output logic              enc,
   output logic              clr_cnt,
   output logic [KEY_W-1:0]  key,
   output logic              key_load,
   output logic              err,
   output logic [BYTE_W-1:0] ack_data,
   output logic              ack_valid,
   input  logic              ack_require
);

   localparam int unsigned TMO_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);

   state_e             state_q, state_d;
   logic [NIB_W-1:0]   nib_q, nib_d;
   logic [KEY_W-1:0]   shift_q, shift_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               work_q, work_d;
   logic               enc_q, enc_d;
   logic               clr_q, clr_d;
   logic               kl_q, kl_d;
   logic               err_q, err_d;
   logic [BYTE_W-1:0]  ack_data_q, ack_data_d;
   logic               ack_valid_q, ack_valid_d;

   logic               is_hex;
   logic [3:0]         nibble;
   logic               ack_set;
   logic [BYTE_W-1:0]  ack_byte;
   logic [KEY_W-1:0]   shifted;

   ascii_hex_decode u_hex (
      .data_i   (rx_data),
      .is_hex_o (is_hex),
      .nibble_o (nibble)
   );

   assign shifted = {shift_q[KEY_W-5:0], nibble};

   // Next-state and output decode; an incoming byte always takes priority over timeout.
   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      shift_d     = shift_q;
      key_d       = key_q;
      tmo_d       = tmo_q;
      work_d      = work_q;
      enc_d       = enc_q;
      clr_d       = 1'b0;
      kl_d        = 1'b0;
      err_d       = 1'b0;
      ack_set     = 1'b0;
      ack_byte    = ASCII_O;
      ack_data_d  = ack_data_q;
      ack_valid_d = ack_valid_q & ~ack_require;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  ASCII_S: begin work_d = 1'b1; ack_set = 1'b1; end
                  ASCII_P: begin work_d = 1'b0; ack_set = 1'b1; end
                  ASCII_E: begin enc_d  = 1'b1; ack_set = 1'b1; end
                  ASCII_D: begin enc_d  = 1'b0; ack_set = 1'b1; end
                  ASCII_C: begin clr_d  = 1'b1; ack_set = 1'b1; end
                  ASCII_K: begin
                     state_d = ST_KEY;
                     nib_d   = '0;
                     shift_d = '0;
                     tmo_d   = TMO_W'(TMO_CYCLES);
                  end
                  ASCII_CR, ASCII_LF, ASCII_SP: ;
                  default: begin
                     err_d    = 1'b1;
                     ack_set  = 1'b1;
                     ack_byte = ASCII_X;
                  end
               endcase
            end
         end
         ST_KEY: begin
            if (rx_valid) begin
               if (is_hex) begin
                  shift_d = shifted;
                  tmo_d   = TMO_W'(TMO_CYCLES);
                  if (nib_q == NIB_W'(31)) begin
                     key_d   = shifted;
                     kl_d    = 1'b1;
                     ack_set = 1'b1;
                     nib_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     nib_d = nib_q + NIB_W'(1);
                  end
               end else begin
                  err_d    = 1'b1;
                  ack_set  = 1'b1;
                  ack_byte = ASCII_X;
                  state_d  = ST_IDLE;
               end
            end else if (tmo_q <= TMO_W'(1)) begin
               tmo_d    = '0;
               err_d    = 1'b1;
               ack_set  = 1'b1;
               ack_byte = ASCII_X;
               state_d  = ST_IDLE;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Newest ack overwrites a pending one; a simultaneous transfer keeps it valid.
      if (ack_set) begin
         ack_valid_d = 1'b1;
         ack_data_d  = ack_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         nib_q       <= '0;
         shift_q     <= '0;
         key_q       <= KEY_DEFAULT;
         tmo_q       <= '0;
         work_q      <= 1'b0;
         enc_q       <= ENC_DEFAULT;
         clr_q       <= 1'b0;
         kl_q        <= 1'b0;
         err_q       <= 1'b0;
         ack_data_q  <= 8'h00;
         ack_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         nib_q       <= nib_d;
         shift_q     <= shift_d;
         key_q       <= key_d;
         tmo_q       <= tmo_d;
         work_q      <= work_d;
         enc_q       <= enc_d;
         clr_q       <= clr_d;
         kl_q        <= kl_d;
         err_q       <= err_d;
         ack_data_q  <= ack_data_d;
         ack_valid_q <= ack_valid_d;
      end
   end

   assign work      = work_q;
   assign enc       = enc_q;
   assign clr_cnt   = clr_q;
   assign key       = key_q;
   assign key_load  = kl_q;
   assign err       = err_q;
   assign ack_data  = ack_data_q;
   assign ack_valid = ack_valid_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a byte-level reference model queues the expected
// state at each ack, and a forked monitor compares at every ack transfer.
module tb_uart_cmd_parser;

   localparam int unsigned CLK_FREQ   = 50_000;
   localparam int unsigned TIMEOUT_MS = 1;
   localparam int unsigned T          = CLK_FREQ / 1000 * TIMEOUT_MS;

   logic         clk;
   logic         rst;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         work;
   logic         enc;
   logic         clr_cnt;
   logic [127:0] key;
   logic         key_load;
   logic         err;
   logic [7:0]   ack_data;
   logic         ack_valid;
   logic         ack_require;

   uart_cmd_parser #(
      .CLK_FREQ    (CLK_FREQ),
      .TIMEOUT_MS  (TIMEOUT_MS),
      .ENC_DEFAULT (1'b1),
      .KEY_DEFAULT (128'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .work        (work),
      .enc         (enc),
      .clr_cnt     (clr_cnt),
      .key         (key),
      .key_load    (key_load),
      .err         (err),
      .ack_data    (ack_data),
      .ack_valid   (ack_valid),
      .ack_require (ack_require)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]   ack;
      logic         work;
      logic         enc;
      logic         clr;
      logic         kl;
      logic         err;
      logic [127:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;
   bit   mon_en;

   // Reference model state: what the host has commanded so far.
   bit           m_work;
   bit           m_enc;
   bit           m_in_key;
   int           m_digits;
   logic [127:0] m_key;
   logic [127:0] m_sh;
   int           idle_run;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic bit hex_val(input logic [7:0] b, output logic [3:0] v);
      v = 4'h0;
      if (b >= "0" && b <= "9") begin v = 4'(b - "0");        return 1'b1; end
      if (b >= "A" && b <= "F") begin v = 4'(b - "A" + 8'd10); return 1'b1; end
      if (b >= "a" && b <= "f") begin v = 4'(b - "a" + 8'd10); return 1'b1; end
      return 1'b0;
   endfunction

   task automatic push(input logic [7:0] a, input bit c, input bit k, input bit e);
      exp_t x;
      x.ack = a; x.work = m_work; x.enc = m_enc;
      x.clr = c; x.kl = k; x.err = e; x.key = m_key;
      exp_q.push_back(x);
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [3:0] v;
      if (!m_in_key) begin
         case (b)
            "S": begin m_work = 1'b1; push("O", 0, 0, 0); end
            "P": begin m_work = 1'b0; push("O", 0, 0, 0); end
            "E": begin m_enc  = 1'b1; push("O", 0, 0, 0); end
            "D": begin m_enc  = 1'b0; push("O", 0, 0, 0); end
            "C": push("O", 1, 0, 0);
            "K": begin m_in_key = 1'b1; m_digits = 0; m_sh = '0; end
            8'h0D, 8'h0A, 8'h20: ;
            default: push("X", 0, 0, 1);
         endcase
      end else if (hex_val(b, v)) begin
         m_sh = (m_sh << 4) | 128'(v);
         m_digits++;
         if (m_digits == 32) begin
            m_key    = m_sh;
            m_in_key = 1'b0;
            push("O", 0, 1, 0);
         end
      end else begin
         m_in_key = 1'b0;
         push("X", 0, 0, 1);
      end
   endtask

   // Strobe one byte for a single cycle; called at a falling edge, returns at one.
   task automatic send(input logic [7:0] b);
      model_byte(b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      idle_run = 0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // A key sequence times out once T whole cycles pass with no byte.
   task automatic do_idle(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         idle_run++;
         if (m_in_key && idle_run == int'(T)) begin
            m_in_key = 1'b0;
            push("X", 0, 0, 1);
         end
      end
   endtask

   task automatic monitor();
      exp_t got;
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && !rst) begin
            got.ack = ack_data; got.work = work; got.enc = enc;
            got.clr = clr_cnt;  got.kl = key_load; got.err = err; got.key = key;
            if (ack_valid && ack_require) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ack", 160'(got), 160'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("ack_tuple", 160'(got), 160'(e));
               end
            end else if (clr_cnt || key_load || err) begin
               check("pulse_without_ack", 160'({clr_cnt, key_load, err}), 160'(0));
            end
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_queue_empty", 160'(exp_q.size()), 160'(0));
   endtask

   initial begin
      string cmds;
      string hexs;
      int    r;
      int    g;
      vectors     = 0;
      miscompares = 0;
      mon_en      = 1'b0;
      m_work = 1'b0; m_enc = 1'b1; m_in_key = 1'b0; m_digits = 0;
      m_key = '0; m_sh = '0; idle_run = 0;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack_require = 1'b0;
      cmds = "SPEDCKK \r\nQs1";
      hexs = "0123456789ABCDEFabcdef";
      fork monitor(); join_none

      // Reset values with no stimulus.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_work",      160'(work),      160'(0));
      check("rst_enc",       160'(enc),       160'(1));
      check("rst_key",       160'(key),       160'(0));
      check("rst_ack_valid", 160'(ack_valid), 160'(0));
      check("rst_ack_data",  160'(ack_data),  160'(0));

      mon_en      = 1'b1;
      ack_require = 1'b1;
      send("S");
      send("D");
      do_idle(3);
      send_str("K00112233445566778899AABBCCDDEEFF");
      do_idle(3);
      drain();
      check("key_constant", 160'(key), 160'(128'h00112233_44556677_8899AABB_CCDDEEFF));

      send_str("K12345G");
      send("S");
      do_idle(2);
      send_str("Kabc");
      do_idle(T + 3);
      send("C");
      // Boundary: a digit arriving on the last allowed cycle keeps the sequence alive.
      send_str("K1");
      do_idle(T - 1);
      send("2");
      do_idle(T + 2);
      drain();

      for (int n = 0; n < 700; n++) begin
         r = int'($urandom_range(0, 99));
         g = (r < 2) ? int'(T) - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
         do_idle(g);
         r = int'($urandom_range(0, 99));
         if (m_in_key && r < 98) send(hexs[int'($urandom_range(0, hexs.len() - 1))]);
         else if (m_in_key) send("Z");
         else send(cmds[int'($urandom_range(0, cmds.len() - 1))]);
      end
      do_idle(T + 5);
      drain();

      // Held ack is overwritten by the newest one, then clears after a single transfer.
      mon_en      = 1'b0;
      ack_require = 1'b0;
      @(negedge clk);
      send("S");
      send("Q");
      @(negedge clk);
      check("hold_ack_valid", 160'(ack_valid), 160'(1));
      check("hold_ack_data",  160'(ack_data),  160'("X"));
      check("hold_work",      160'(work),      160'(1));
      exp_q.delete();
      ack_require = 1'b1;
      @(negedge clk);
      ack_require = 1'b0;
      check("ack_cleared", 160'(ack_valid), 160'(0));
      @(negedge clk);
      check("ack_stays_clear", 160'(ack_valid), 160'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
